regfile_wb_scheduler: RTL and testbench

//  Merges two writeback sources onto the single register-file write port: A (ALU) and M (load/memory).

---
 rtl/wb_pkg.sv | 8 +
 rtl/regfile_wb_scheduler_if.sv | 22 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/regfile_wb_scheduler.sv | 74 +++++++
 tb/tb_regfile_wb_scheduler.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: source tags and default widths shared by the writeback scheduler
package wb_pkg;
  typedef logic src_t;
  localparam src_t SRC_A = 1'b0;
  localparam src_t SRC_M = 1'b1;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: writeback sources, register-file write port and hazard-check signals
interface regfile_wb_scheduler_if import wb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic              a_valid, a_ready, m_valid, m_ready;
  logic [ADDR_W-1:0] a_addr, m_addr;
  logic [DATA_W-1:0] a_data, m_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] chk_addr1, chk_addr2, chk_addr3;
  logic              pend1, pend2, pend3;
  modport master (
    output a_valid, a_addr, a_data, m_valid, m_addr, m_data, chk_addr1, chk_addr2, chk_addr3,
    input  a_ready, m_ready, wr_en, wr_addr, wr_data, pend1, pend2, pend3
  );
  modport slave (
    input  a_valid, a_addr, a_data, m_valid, m_addr, m_data, chk_addr1, chk_addr2, chk_addr3,
    output a_ready, m_ready, wr_en, wr_addr, wr_data, pend1, pend2, pend3
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: sync FIFO with two ordered push ports, one pop, count and key-match over valid entries
module wb_fifo #(
  parameter int W  = 37,
  parameter int D  = 2,
  parameter int KW = 5,
  parameter int NK = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push0,
  input  logic [W-1:0]          din0,
  input  logic                  push1,
  input  logic [W-1:0]          din1,
  input  logic                  pop,
  input  logic [NK-1:0][KW-1:0] keys,
  output logic [W-1:0]          dout,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(D):0]    count,
  output logic [NK-1:0]         hit
);
  localparam int PW = $clog2(D);
  logic [D-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0] cnt_q, cnt_d;
  // push0 lands before push1 so a same-cycle pair keeps its order
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    if (push0) begin
      mem_d[wr_d] = din0;
      wr_d = wr_d + PW'(1);
    end
    if (push1) begin
      mem_d[wr_d] = din1;
      wr_d = wr_d + PW'(1);
    end
    rd_d = rd_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(push0) + (PW+1)'(push1) - (PW+1)'(pop);
  end
  always_comb begin
    hit = '0;
    for (int i = 0; i < D; i++)
      for (int k = 0; k < NK; k++)
        if ({1'b0, PW'(PW'(i) - rd_q)} < cnt_q && mem_q[i][W-1 -: KW] == keys[k]) hit[k] = 1'b1;
  end
  assign dout  = mem_q[rd_q];
  assign full  = cnt_q == (PW+1)'(D);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: merges ALU and load writebacks onto one register-file port in arrival order
module regfile_wb_scheduler import wb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int QDEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_scheduler_if.slave bus
);
  localparam int EW = ADDR_W + DATA_W;
  logic a_push, m_push, a_full, m_full, a_empty, m_empty, ord_full, ord_empty, pop_a, pop_m;
  logic [EW-1:0] a_dout, m_dout;
  src_t head;
  logic [$clog2(QDEPTH):0] a_cnt, m_cnt;
  logic [$clog2(2*QDEPTH):0] ord_cnt;
  logic [2:0][ADDR_W-1:0] chk;
  logic [2:0] a_hit, m_hit, pend, ord_hit_unused;
  logic wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  assign bus.a_ready = rst_n && !a_full;
  assign bus.m_ready = rst_n && !m_full;
  // writes to r0 complete the handshake but are dropped here
  assign a_push = bus.a_valid && bus.a_ready && |bus.a_addr;
  assign m_push = bus.m_valid && bus.m_ready && |bus.m_addr;
  assign pop_a  = !ord_empty && head == SRC_A;
  assign pop_m  = !ord_empty && head == SRC_M;
  assign chk    = {bus.chk_addr3, bus.chk_addr2, bus.chk_addr1};
  wb_fifo #(.W(EW), .D(QDEPTH), .KW(ADDR_W), .NK(3)) u_qa (
    .clk, .rst_n, .push0(a_push), .din0({bus.a_addr, bus.a_data}), .push1(1'b0), .din1('0),
    .pop(pop_a), .keys(chk), .dout(a_dout), .full(a_full), .empty(a_empty), .count(a_cnt), .hit(a_hit)
  );
  wb_fifo #(.W(EW), .D(QDEPTH), .KW(ADDR_W), .NK(3)) u_qm (
    .clk, .rst_n, .push0(m_push), .din0({bus.m_addr, bus.m_data}), .push1(1'b0), .din1('0),
    .pop(pop_m), .keys(chk), .dout(m_dout), .full(m_full), .empty(m_empty), .count(m_cnt), .hit(m_hit)
  );
  wb_fifo #(.W(1), .D(2*QDEPTH), .KW(1), .NK(3)) u_ord (
    .clk, .rst_n, .push0(a_push), .din0(SRC_A), .push1(m_push), .din1(SRC_M),
    .pop(!ord_empty), .keys('0), .dout(head), .full(ord_full), .empty(ord_empty), .count(ord_cnt),
    .hit(ord_hit_unused)
  );
  always_comb begin
    wr_en_d   = !ord_empty;
    wr_addr_d = ord_empty ? wr_addr_q : (head == SRC_M ? m_dout[EW-1 -: ADDR_W] : a_dout[EW-1 -: ADDR_W]);
    wr_data_d = ord_empty ? wr_data_q : (head == SRC_M ? m_dout[DATA_W-1:0] : a_dout[DATA_W-1:0]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  always_comb begin
    pend = '0;
    for (int k = 0; k < 3; k++)
      pend[k] = |chk[k] && (a_hit[k] || m_hit[k] || (wr_en_q && wr_addr_q == chk[k]));
  end
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign {bus.pend3, bus.pend2, bus.pend1} = pend;
  a_ord_count: assert property (@(posedge clk) disable iff (!rst_n)
    32'(ord_cnt) == 32'(a_cnt) + 32'(m_cnt));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_a && a_empty) && !(pop_m && m_empty));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(ord_full && (a_push || m_push)));
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed checks of reset, ordering, backpressure, r0 drop and mid-flight reset
module tb_regfile_wb_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  regfile_wb_scheduler_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_wr(input string tag, input logic en, input logic [4:0] addr, input logic [31:0] data);
    check({tag, "_en"}, bus.wr_en, en);
    check({tag, "_addr"}, bus.wr_addr, addr);
    check({tag, "_data"}, bus.wr_data, data);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h1;
    bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_data = '0;
    bus.chk_addr1 = '0; bus.chk_addr2 = '0; bus.chk_addr3 = '0;
    // reset held with a pending ALU request
    repeat (2) tick;
    check("rst_a_ready", bus.a_ready, 0);
    check("rst_m_ready", bus.m_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    rst_n = 1'b1; bus.a_valid = 1'b0;
    #1;
    check("rel_a_ready", bus.a_ready, 1);
    check("rel_m_ready", bus.m_ready, 1);
    check_wr("rel", 0, 0, 0);
    // single ALU write
    bus.chk_addr1 = 5'd5;
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEAD_BEEF;
    tick;
    bus.a_valid = 1'b0;
    check("s_n_wr_en", bus.wr_en, 0);
    check("s_n_pend1", bus.pend1, 1);
    tick;
    check_wr("s_n1", 1, 5, 32'hDEAD_BEEF);
    check("s_n1_pend1", bus.pend1, 1);
    tick;
    check_wr("s_n2", 0, 5, 32'hDEAD_BEEF);
    check("s_n2_pend1", bus.pend1, 0);
    // same-cycle A and M to r7: A is older
    bus.chk_addr2 = 5'd7;
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'd1;
    bus.m_valid = 1'b1; bus.m_addr = 5'd7; bus.m_data = 32'd2;
    tick;
    bus.a_valid = 1'b0; bus.m_valid = 1'b0;
    check("w_n_wr_en", bus.wr_en, 0);
    check("w_n_pend2", bus.pend2, 1);
    tick;
    check_wr("w_n1", 1, 7, 1);
    check("w_n1_pend2", bus.pend2, 1);
    tick;
    check_wr("w_n2", 1, 7, 2);
    check("w_n2_pend2", bus.pend2, 1);
    tick;
    check("w_n3_wr_en", bus.wr_en, 0);
    check("w_n3_pend2", bus.pend2, 0);
    // backpressure on the load queue
    bus.chk_addr2 = 5'd0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h11;
    bus.m_valid = 1'b1; bus.m_addr = 5'd2; bus.m_data = 32'h21;
    #1;
    check("bp1_a_ready", bus.a_ready, 1);
    check("bp1_m_ready", bus.m_ready, 1);
    tick;
    bus.a_addr = 5'd3; bus.a_data = 32'h12;
    bus.m_addr = 5'd4; bus.m_data = 32'h22;
    #1;
    check("bp2_a_ready", bus.a_ready, 1);
    check("bp2_m_ready", bus.m_ready, 1);
    check("bp2_wr_en", bus.wr_en, 0);
    tick;
    check_wr("bp_r1", 1, 1, 32'h11);
    bus.a_addr = 5'd5; bus.a_data = 32'h13;
    bus.m_addr = 5'd6; bus.m_data = 32'h23;
    #1;
    check("bp3_a_ready", bus.a_ready, 1);
    check("bp3_m_ready_full", bus.m_ready, 0);
    tick;
    check_wr("bp_r2", 1, 2, 32'h21);
    bus.a_valid = 1'b0;
    #1;
    check("bp4_a_ready_full", bus.a_ready, 0);
    check("bp4_m_ready", bus.m_ready, 1);
    tick;
    bus.m_valid = 1'b0;
    check_wr("bp_r3", 1, 3, 32'h12);
    tick;
    check_wr("bp_r4", 1, 4, 32'h22);
    tick;
    check_wr("bp_r5", 1, 5, 32'h13);
    tick;
    check_wr("bp_r6", 1, 6, 32'h23);
    tick;
    check_wr("bp_idle", 0, 6, 32'h23);
    // r0 handshake is accepted but never written
    bus.chk_addr1 = 5'd0; bus.chk_addr3 = 5'd0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hFFFF;
    #1;
    check("z_a_ready", bus.a_ready, 1);
    tick;
    bus.a_valid = 1'b0;
    check("z_n_wr_en", bus.wr_en, 0);
    check("z_n_pend1", bus.pend1, 0);
    tick;
    check_wr("z_n1", 0, 6, 32'h23);
    tick;
    check("z_n2_wr_en", bus.wr_en, 0);
    // reset with entries queued and one write in flight
    bus.chk_addr1 = 5'd9; bus.chk_addr2 = 5'd10; bus.chk_addr3 = 5'd11;
    bus.a_valid = 1'b1; bus.a_addr = 5'd9; bus.a_data = 32'h91;
    bus.m_valid = 1'b1; bus.m_addr = 5'd10; bus.m_data = 32'hA1;
    tick;
    bus.a_addr = 5'd11; bus.a_data = 32'hB1; bus.m_valid = 1'b0;
    #1;
    check("f_pend1", bus.pend1, 1);
    check("f_pend2", bus.pend2, 1);
    tick;
    bus.a_valid = 1'b0;
    check_wr("f_r9", 1, 9, 32'h91);
    check("f_pend3", bus.pend3, 1);
    rst_n = 1'b0;
    #1;
    check("f_rst_a_ready", bus.a_ready, 0);
    tick;
    rst_n = 1'b1;
    #1;
    check_wr("f_rel", 0, 0, 0);
    check("f_rel_pend1", bus.pend1, 0);
    check("f_rel_pend2", bus.pend2, 0);
    check("f_rel_pend3", bus.pend3, 0);
    check("f_rel_a_ready", bus.a_ready, 1);
    check("f_rel_m_ready", bus.m_ready, 1);
    tick;
    check("f_post1_wr_en", bus.wr_en, 0);
    tick;
    check("f_post2_wr_en", bus.wr_en, 0);
    // traffic after the flush still drains in order
    bus.m_valid = 1'b1; bus.m_addr = 5'd12; bus.m_data = 32'hC1;
    tick;
    bus.m_valid = 1'b0;
    tick;
    check_wr("p_r12", 1, 12, 32'hC1);
    tick;
    check("p_idle_wr_en", bus.wr_en, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
